// File: rtl/wg_nlfsr_seq.sv
// Self-sequencing WG-style NLFSR: key load, initialisation rounds and a
// valid/ready keystream phase over N stages of W-bit words.
module wg_nlfsr_seq #(
  parameter int             W           = 5,
  parameter int             N           = 6,
  parameter int             TAP         = 1,
  parameter int             OUT_TAP     = 1,
  parameter logic [W-1:0]   GAMMA       = 5'b10011,
  parameter int             INIT_ROUNDS = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         key_valid,
  input  logic [W-1:0] key_word,
  output logic         key_ready,
  input  logic [W-1:0] tk,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_bit,
  output logic         busy
);

  localparam int BW = $clog2(N + 1);
  localparam int RW = $clog2(INIT_ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD, INIT, RUN} state_e;

  state_e              state_q;
  logic [N-1:0][W-1:0] stage_q;
  logic [BW-1:0]       beat_q;
  logic [RW-1:0]       round_q;
  logic                g;
  logic [W-1:0]        fb_d;

  // Nonlinear filter: parity(x ^ (rotl(x,1) & rotl(x,2))).
  function automatic logic nl(input logic [W-1:0] x);
    logic [W-1:0] r1;
    logic [W-1:0] r2;
    r1 = {x[W-2:0], x[W-1]};
    r2 = {x[W-3:0], x[W-1:W-2]};
    return ^(x ^ (r1 & r2));
  endfunction

  always_comb begin
    g    = nl(stage_q[N-1]);
    fb_d = stage_q[TAP] ^ tk ^ {{(W-1){1'b0}}, g} ^ (g ? GAMMA : '0);
  end

  // NOTE: the stages are a handful of flops rather than a RAM, so they are
  // cleared on reset and on stop together with the FSM and counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      stage_q <= '0;
      beat_q  <= '0;
      round_q <= '0;
    end else if (state_q != IDLE && stop) begin
      state_q <= IDLE;
      stage_q <= '0;
      beat_q  <= '0;
      round_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LOAD;
            beat_q  <= '0;
          end
        end
        LOAD: begin
          if (key_valid) begin
            stage_q <= {key_word, stage_q[N-1:1]};
            beat_q  <= beat_q + BW'(1);
            if (beat_q == BW'(N - 1)) begin
              state_q <= INIT;
              round_q <= '0;
            end
          end
        end
        INIT: begin
          stage_q <= {fb_d, stage_q[N-1:1]};
          round_q <= round_q + RW'(1);
          if (round_q == RW'(INIT_ROUNDS - 1)) state_q <= RUN;
        end
        RUN: begin
          if (out_ready) stage_q <= {fb_d, stage_q[N-1:1]};
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = (state_q != IDLE);
  assign key_ready = (state_q == LOAD);
  assign out_valid = (state_q == RUN);
  assign out_bit   = out_valid & nl(stage_q[OUT_TAP]);

endmodule

// File: tb/tb_wg_nlfsr_seq.sv
// Directed bench for wg_nlfsr_seq: a queue-based reference model checked every
// cycle, plus hand-computed literal expectations and stream comparisons.
module tb_wg_nlfsr_seq;

  localparam int          W   = 5;
  localparam int          N   = 6;
  localparam int          TAP = 1;
  localparam int          OT  = 1;
  localparam int unsigned GAM = 5'b10011;
  localparam int          IR  = 12;
  localparam int unsigned MSK = (1 << W) - 1;

  localparam int M_IDLE = 0, M_LOAD = 1, M_INIT = 2, M_RUN = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         key_valid = 1'b0;
  logic [W-1:0] key_word = '0;
  logic         key_ready;
  logic [W-1:0] tk = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         out_bit;
  logic         busy;

  int checks = 0;
  int errors = 0;

  wg_nlfsr_seq #(.W(W), .N(N), .TAP(TAP), .OUT_TAP(OT), .GAMMA(5'b10011),
                 .INIT_ROUNDS(IR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop),
    .key_valid(key_valid), .key_word(key_word), .key_ready(key_ready),
    .tk(tk), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .busy(busy));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int unsigned st[$];
  int          m_mode = M_IDLE;
  int          m_beats = 0;
  int          m_rounds = 0;
  bit          m_valid = 1'b0;
  int          edge_cnt = 0;

  function automatic int unsigned nl_m(input int unsigned x);
    int unsigned p = 0;
    for (int i = 0; i < W; i++) begin
      int unsigned a, b, c;
      a = (x >> i) & 1;
      b = (x >> ((i + W - 1) % W)) & 1;
      c = (x >> ((i + W - 2) % W)) & 1;
      p = p ^ (a ^ (b & c));
    end
    return p;
  endfunction

  function automatic int unsigned fb_m(input int unsigned top, input int unsigned tapv,
                                       input int unsigned tkv);
    int unsigned g, v;
    g = nl_m(top);
    v = tapv ^ tkv ^ g;
    if (g != 0) v = v ^ GAM;
    return v & MSK;
  endfunction

  task automatic m_clear();
    st.delete();
    for (int i = 0; i < N; i++) st.push_back(0);
    m_mode   = M_IDLE;
    m_beats  = 0;
    m_rounds = 0;
  endtask

  task automatic m_shift(input int unsigned v);
    void'(st.pop_front());
    st.push_back(v & MSK);
  endtask

  always @(posedge clk) begin
    edge_cnt++;
    if (!rst_n) begin
      m_clear();
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (m_mode != M_IDLE && stop) m_clear();
      else begin
        case (m_mode)
          M_IDLE: if (start) begin m_mode = M_LOAD; m_beats = 0; end
          M_LOAD: if (key_valid) begin
            m_shift(key_word);
            m_beats++;
            if (m_beats == N) begin m_mode = M_INIT; m_rounds = 0; end
          end
          M_INIT: begin
            m_shift(fb_m(st[N-1], st[TAP], tk));
            m_rounds++;
            if (m_rounds == IR) m_mode = M_RUN;
          end
          default: if (out_ready) m_shift(fb_m(st[N-1], st[TAP], tk));
        endcase
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  bit cap[$];
  int acc_cnt = 0;
  bit prev_stall = 1'b0;
  bit prev_bit = 1'b0;

  always @(negedge clk) begin
    if (m_valid) begin
      logic [N*W-1:0] expv;
      for (int i = 0; i < N; i++) expv[i*W +: W] = st[i][W-1:0];
      check("busy", busy, m_mode != M_IDLE);
      check("key_ready", key_ready, m_mode == M_LOAD);
      check("out_valid", out_valid, m_mode == M_RUN);
      check("out_bit", out_bit, (m_mode == M_RUN) ? nl_m(st[OT]) : 0);
      check("stages", dut.stage_q, expv);
      if (prev_stall && out_valid) check("stall_hold", out_bit, prev_bit);
      if (key_valid && key_ready && !stop) acc_cnt++;
      if (out_valid && out_ready && !stop) cap.push_back(out_bit);
      prev_stall = out_valid && !out_ready && !stop && rst_n;
      prev_bit   = out_bit;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic load_key(input logic [W-1:0] k [N], input bit gaps);
    for (int i = 0; i < N; i++) begin
      key_valid = 1'b1;
      key_word  = k[i];
      tick();
      if (gaps && i < N - 1) begin
        key_valid = 1'b0;
        key_word  = ~k[i];
        tick();
        tick();
      end
    end
    key_valid = 1'b0;
  endtask

  task automatic collect(input int n, input bit rnd);
    int cyc = 0;
    cap.delete();
    while (cap.size() < n && cyc < 4000) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      cyc++;
    end
    out_ready = 1'b0;
    check("collect_count", cap.size(), n);
  endtask

  task automatic wait_run(output int edges_seen);
    int cyc = 0;
    while (!out_valid && cyc < 100) begin
      tick();
      cyc++;
    end
    edges_seen = cyc;
    check("reached_run", out_valid, 1'b1);
  endtask

  task automatic stop_now(input string name, input bit with_ready);
    stop      = 1'b1;
    out_ready = with_ready;
    tick();
    stop      = 1'b0;
    out_ready = 1'b0;
    check({name, "_busy"}, busy, 1'b0);
    check({name, "_stages"}, dut.stage_q, 0);
  endtask

  task automatic cmp_stream(input string name, input bit a[$], input bit b[$]);
    int mis = 0;
    for (int i = 0; i < a.size() && i < b.size(); i++) if (a[i] != b[i]) mis++;
    check({name, "_len"}, a.size(), b.size());
    check({name, "_mismatches"}, mis, 0);
  endtask

  // ---------------- directed sequence ----------------
  logic [W-1:0]        zk [N];
  logic [W-1:0]        kk [N];
  logic [N-1:0][W-1:0] load_snap;
  bit                  ref_q[$];
  int                  e_start, lat, ones;

  initial begin
    zk = '{default: '0};
    kk = '{5'h13, 5'h07, 5'h1c, 5'h0a, 5'h15, 5'h02};

    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_busy", busy, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_key_ready", key_ready, 1'b0);
    check("rst_out_bit", out_bit, 1'b0);
    check("rst_stages", dut.stage_q, 0);
    rst_n = 1'b1;
    tick();

    // Zero key, tk=0: latency and an all-zero keystream
    tk = '0;
    start_session();
    e_start = edge_cnt;
    check("start_key_ready", key_ready, 1'b1);
    load_key(zk, 1'b0);
    check("key_ready_drop", key_ready, 1'b0);
    wait_run(lat);
    check("latency_18", edge_cnt - e_start, 18);
    collect(64, 1'b0);
    ones = 0;
    foreach (cap[i]) ones += int'(cap[i]);
    check("zero_key_ones", ones, 0);
    stop_now("stop_run_xfer0", 1'b1);

    // Zero key, tk=1: first two INIT edges by hand
    tk = 5'b00001;
    start_session();
    load_key(zk, 1'b0);
    tick();
    check("init1_s5", dut.stage_q[5], 5'b00001);
    check("init1_s4_0", dut.stage_q[4:0], 0);
    tick();
    check("init2_s5", dut.stage_q[5], 5'b10011);
    check("init2_s4", dut.stage_q[4], 5'b00001);
    wait_run(lat);
    collect(64, 1'b0);
    stop_now("stop_run_tk1", 1'b0);

    // Reference session: gap-free load, out_ready held high
    tk = 5'h0b;
    start_session();
    load_key(kk, 1'b0);
    load_snap = dut.stage_q;
    check("first_word_s0", dut.stage_q[0], 5'h13);
    check("last_word_s5", dut.stage_q[5], 5'h02);
    wait_run(lat);
    collect(48, 1'b0);
    ref_q = cap;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_run_busy", busy, 1'b1);
    check("start_in_run_valid", out_valid, 1'b1);
    stop_now("stop_run_ref", 1'b1);

    // Gapped load must match the gap-free load
    start_session();
    acc_cnt = 0;
    load_key(kk, 1'b1);
    check("gap_snapshot", dut.stage_q, load_snap);
    key_valid = 1'b1;
    key_word  = 5'h1f;
    repeat (3) tick();
    key_valid = 1'b0;
    check("gap_accepts", acc_cnt, N);
    wait_run(lat);
    collect(48, 1'b0);
    cmp_stream("gap_stream", cap, ref_q);
    stop_now("stop_run_gap", 1'b0);

    // Backpressure: random out_ready, same accepted sequence
    start_session();
    load_key(kk, 1'b0);
    wait_run(lat);
    collect(48, 1'b1);
    cmp_stream("bp_stream", cap, ref_q);
    stop_now("stop_run_bp", 1'b0);

    // stop in LOAD after 3 beats, on the cycle of a 4th beat
    start_session();
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1;
      key_word  = kk[i];
      tick();
    end
    key_word  = kk[3];
    stop_now("stop_load", 1'b0);
    key_valid = 1'b0;

    // stop in INIT
    start_session();
    load_key(kk, 1'b0);
    repeat (4) tick();
    stop_now("stop_init", 1'b0);

    // Fresh session after stops matches the reference
    start_session();
    load_key(kk, 1'b0);
    wait_run(lat);
    collect(48, 1'b0);
    cmp_stream("restart_stream", cap, ref_q);

    // Reset asserted mid-RUN
    out_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    out_ready = 1'b0;
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_valid", out_valid, 1'b0);
    check("midrun_rst_stages", dut.stage_q, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wg_nlfsr_seq.md
# wg_nlfsr_seq

Parametrised, self-sequencing successor to the team's fixed 6×5-bit WG-style NLFSR stage. Holds N stages of W-bit words with a tweak-driven nonlinear feedback path. It also sequences its own key load, initialisation rounds and keystream phase. Keystream bits leave through a valid/ready handshake with backpressure, so it sits directly in front of the TRNG post-processing / output FIFO path.

## Interface
- W, 5: stage word width (≥3).
- N, 6: number of stages S[N-1]..S[0] (≥3).
- TAP, 1: stage index XORed into feedback (0..N-2).
- OUT_TAP, 1: stage index driving the keystream filter (0..N-1).
- GAMMA, 5'b10011: W-bit constant added to feedback when the nonlinear bit is 1.
- INIT_ROUNDS, 12: initialisation clock count (≥1).

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  begin a session; honoured only in IDLE.
- stop  in  1  abort/finish session from any non-IDLE state.
- key_valid  in  1  key word offered.
- key_word  in  W  key word.
- key_ready  out  1  block accepts key words (high only in LOAD).
- tk  in  W  tweak word; must be held stable from start until stop.
- out_valid  out  1  keystream bit available (high only in RUN).
- out_ready  in  1  consumer accepts bit.
- out_bit  out  1  keystream bit; 0 whenever out_valid=0.
- busy  out  1  state ≠ IDLE.

## Operation
- NL(x), W→1: parity(x ^ (rotl(x,1) & rotl(x,2))), where rotl is a W-bit rotate left.
- g = NL(S[N-1]). pad = {(W-1)'b0, g}. gam = g ? GAMMA : 0.
- fb = S[TAP] ^ tk ^ pad ^ gam. All XORs are W-bit; there is no arithmetic carry.
- A shift performs S[N-1] <= new, and S[i] <= S[i+1] for i < N-1.
- FSM states: IDLE, LOAD, INIT, RUN.
  - IDLE: stages hold. When start=1, clear a beat counter and go to LOAD.
  - LOAD: key_ready=1. Each cycle with key_valid=1 shifts with new=key_word. When key_valid=0 the stages hold. After the N-th accepted word, go to INIT with the round counter at 0. The first word accepted ends up in S[0].
  - INIT: shifts every cycle with new=fb. The round counter increments each cycle. After INIT_ROUNDS shifts, go to RUN.
  - RUN: out_valid=1 and out_bit=NL(S[OUT_TAP]). A shift with new=fb happens only on cycles where out_valid && out_ready. Otherwise the stages and out_bit hold.
- stop=1 in LOAD, INIT or RUN forces IDLE on the next edge and clears all stages and counters to 0. stop has priority over every other transition, including a same-cycle key beat or output transfer, neither of which takes effect.
- start while busy=1 is ignored. start and stop together in IDLE: start wins, because stop has no effect in IDLE.
- Counter widths: clog2(N+1) for key beats, clog2(INIT_ROUNDS+1) for rounds. The counters never wrap within a session.

## Timing
- Reset: when rst_n=0 at a rising edge, all stages and counters become 0, the state becomes IDLE, and key_ready, out_valid, out_bit and busy become 0. This applies mid-session too.
- start sampled at edge e: busy=1 and key_ready=1 from e onward.
- Key beats can be back-to-back, one per cycle. With no gaps, the N-th beat is accepted at edge e+N. INIT then occupies edges e+N+1..e+N+INIT_ROUNDS, and out_valid rises after edge e+N+INIT_ROUNDS.
- Minimum start-to-first-bit latency is N+INIT_ROUNDS edges (18 at defaults).
- Keystream throughput is 1 bit per cycle while out_ready=1. out_bit changes only after a transfer.
- All outputs are registered-state decodes. There are no combinational paths from input to output except out_bit, which derives from stage registers only.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, including once mid-RUN. Next edge must give state IDLE, busy=0, out_valid=0, key_ready=0, out_bit=0, and all stages 0.
- Zero key, tk=0, defaults: key_ready must drop after the 6th beat, out_valid must rise exactly 18 edges after start, and out_bit must stay 0 for 64 transfers.
- Zero key, tk=5'b00001: after the first INIT edge, S[5]=5'b00001 and S[4..0]=0. The first 64 bits must match the bench model of the equations above.
- key_valid gaps (pattern 1,0,0,1,…): exactly 6 accepted words, with the stages holding on gap cycles. The result must be identical to a gap-free load of the same words.
- Backpressure: toggle out_ready pseudo-randomly. The accepted bit sequence must equal the out_ready=1 sequence, and out_bit must be stable while stalled.
- stop in LOAD (after 3 beats), in INIT and in RUN, including on the same cycle as a transfer: next edge IDLE with stages 0. A following start behaves as from reset. start asserted mid-RUN is ignored.
